// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set controller.
package rtc_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned FS_W  = 2;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_SET_HR,
    ST_SET_MIN,
    ST_SET_SEC
  } rtc_set_state_t;

  // Six-digit BCD time as handed to the counter chain's load path
  typedef struct packed {
    bcd_t hr_m;
    bcd_t hr_l;
    bcd_t min_m;
    bcd_t min_l;
    bcd_t sec_m;
    bcd_t sec_l;
  } bcd_time_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t HR_MAX_M = 4'd2;
  localparam bcd_t HR_MAX_L = 4'd3;
  localparam bcd_t MS_MAX_M = 4'd5;
  localparam bcd_t MS_MAX_L = 4'd9;

  localparam logic [FS_W-1:0] FS_NONE = 2'b00;
  localparam logic [FS_W-1:0] FS_HR   = 2'b01;
  localparam logic [FS_W-1:0] FS_MIN  = 2'b10;
  localparam logic [FS_W-1:0] FS_SEC  = 2'b11;

  function automatic logic [FS_W-1:0] state_to_fs(input rtc_set_state_t s);
    case (s)
      ST_SET_HR:  return FS_HR;
      ST_SET_MIN: return FS_MIN;
      ST_SET_SEC: return FS_SEC;
      default:    return FS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Two-digit BCD increment with wrap to 00 at (max_m,max_l); any out-of-range
// input also lands on 00 so the digits are legal after one step.
module bcd2_wrap_inc
  import rtc_pkg::*;
(
  input  logic [3:0] i_msd,
  input  logic [3:0] i_lsd,
  input  logic [3:0] i_max_m,
  input  logic [3:0] i_max_l,
  output logic [3:0] o_msd,
  output logic [3:0] o_lsd
);

  logic w_wrap;

  always_comb begin
    w_wrap = (i_lsd > BCD_MAX) || (i_msd > i_max_m) ||
             ((i_msd == i_max_m) && (i_lsd >= i_max_l));
    o_msd  = i_msd;
    o_lsd  = i_lsd;
    if (w_wrap) begin
      o_msd = 4'd0;
      o_lsd = 4'd0;
    end else if (i_lsd == BCD_MAX) begin
      o_msd = i_msd + 4'd1;
      o_lsd = 4'd0;
    end else begin
      o_lsd = i_lsd + 4'd1;
    end
  end

endmodule

// File: rtl/rtc_time_setter.sv
// Two-button time-set controller feeding the RTC parallel-load path.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the inc button.
module rtc_time_setter
  import rtc_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 32'd600_000_000
`ifdef AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY = 32'd50_000_000,
  parameter int unsigned REPEAT_PER = 32'd10_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [3:0] cur_hrm,
  input  logic [3:0] cur_hrl,
  input  logic [3:0] cur_minm,
  input  logic [3:0] cur_minl,
  input  logic [3:0] cur_secm,
  input  logic [3:0] cur_secl,
  output logic [3:0] set_hrm,
  output logic [3:0] set_hrl,
  output logic [3:0] set_minm,
  output logic [3:0] set_minl,
  output logic [3:0] set_secm,
  output logic [3:0] set_secl,
  output logic       load,
  output logic       setting,
  output logic [1:0] field_sel
);

  localparam int unsigned     CNT_W     = 32;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  rtc_set_state_t    r_state, w_state_next;
  bcd_time_t         r_set, w_set_next, w_cur;
  logic              r_load, w_load_next;
  logic              r_setting;
  logic [FS_W-1:0]   r_field_sel;
  logic [CNT_W-1:0]  r_idle, w_idle_next;
  logic              r_mode_q, r_inc_q;
  logic              w_mode_press, w_inc_raw, w_inc_press, w_rpt_fire, w_inc_step;
  bcd_t              w_hr_m, w_hr_l, w_min_m, w_min_l, w_sec_m, w_sec_l;

  assign w_cur        = {cur_hrm, cur_hrl, cur_minm, cur_minl, cur_secm, cur_secl};
  assign w_mode_press = mode_btn & ~r_mode_q;
  assign w_inc_raw    = inc_btn & ~r_inc_q;
  // Mode wins a same-cycle collision; the inc press is dropped
  assign w_inc_press  = w_inc_raw & ~w_mode_press;
  assign w_inc_step   = w_inc_press | w_rpt_fire;

  bcd2_wrap_inc u_hr_inc (
    .i_msd(r_set.hr_m), .i_lsd(r_set.hr_l), .i_max_m(HR_MAX_M), .i_max_l(HR_MAX_L),
    .o_msd(w_hr_m), .o_lsd(w_hr_l)
  );

  bcd2_wrap_inc u_min_inc (
    .i_msd(r_set.min_m), .i_lsd(r_set.min_l), .i_max_m(MS_MAX_M), .i_max_l(MS_MAX_L),
    .o_msd(w_min_m), .o_lsd(w_min_l)
  );

  bcd2_wrap_inc u_sec_inc (
    .i_msd(r_set.sec_m), .i_lsd(r_set.sec_l), .i_max_m(MS_MAX_M), .i_max_l(MS_MAX_L),
    .o_msd(w_sec_m), .o_lsd(w_sec_l)
  );

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PER);

  logic [CNT_W-1:0] r_hold, w_hold_next;
  logic             r_rpt_on, w_rpt_on_next;

  // Hold counter: 0 = idle, otherwise cycles since the press or last repeat
  always_comb begin
    w_hold_next   = r_hold;
    w_rpt_on_next = r_rpt_on;
    w_rpt_fire    = 1'b0;
    if ((r_state == ST_RUN) || !inc_btn || w_mode_press) begin
      w_hold_next   = '0;
      w_rpt_on_next = 1'b0;
    end else if (w_inc_press) begin
      w_hold_next   = CNT_W'(1);
      w_rpt_on_next = 1'b0;
    end else if (r_hold != '0) begin
      if (r_hold == (r_rpt_on ? RPT_PER : RPT_DLY)) begin
        w_rpt_fire    = 1'b1;
        w_rpt_on_next = 1'b1;
        w_hold_next   = CNT_W'(1);
      end else begin
        w_hold_next = r_hold + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold   <= '0;
      r_rpt_on <= 1'b0;
    end else begin
      r_hold   <= w_hold_next;
      r_rpt_on <= w_rpt_on_next;
    end
  end
`else
  assign w_rpt_fire = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_set_next   = r_set;
    w_load_next  = 1'b0;
    w_idle_next  = '0;
    case (r_state)
      ST_RUN: begin
        if (w_mode_press) begin
          w_set_next   = w_cur;
          w_state_next = ST_SET_HR;
        end
      end
      ST_SET_HR: begin
        if (w_mode_press) begin
          w_state_next = ST_SET_MIN;
        end else if (w_inc_step) begin
          w_set_next.hr_m = w_hr_m;
          w_set_next.hr_l = w_hr_l;
        end
      end
      ST_SET_MIN: begin
        if (w_mode_press) begin
          w_state_next = ST_SET_SEC;
        end else if (w_inc_step) begin
          w_set_next.min_m = w_min_m;
          w_set_next.min_l = w_min_l;
        end
      end
      ST_SET_SEC: begin
        if (w_mode_press) begin
          w_load_next  = 1'b1;
          w_state_next = ST_RUN;
        end else if (w_inc_step) begin
          w_set_next.sec_m = w_sec_m;
          w_set_next.sec_l = w_sec_l;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
    // Inactivity abort: back to RUN without a load, edits kept on set_*
    if (r_state != ST_RUN) begin
      if (w_mode_press || w_inc_raw || w_rpt_fire) begin
        w_idle_next = '0;
      end else if (r_idle == IDLE_LAST) begin
        w_state_next = ST_RUN;
      end else begin
        w_idle_next = r_idle + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_set       <= '0;
      r_load      <= 1'b0;
      r_setting   <= 1'b0;
      r_field_sel <= FS_NONE;
      r_idle      <= '0;
      r_mode_q    <= 1'b1;
      r_inc_q     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_set       <= w_set_next;
      r_load      <= w_load_next;
      r_setting   <= (w_state_next != ST_RUN);
      r_field_sel <= state_to_fs(w_state_next);
      r_idle      <= w_idle_next;
      r_mode_q    <= mode_btn;
      r_inc_q     <= inc_btn;
    end
  end

  assign set_hrm   = r_set.hr_m;
  assign set_hrl   = r_set.hr_l;
  assign set_minm  = r_set.min_m;
  assign set_minl  = r_set.min_l;
  assign set_secm  = r_set.sec_m;
  assign set_secl  = r_set.sec_l;
  assign load      = r_load;
  assign setting   = r_setting;
  assign field_sel = r_field_sel;

endmodule

// File: tb/tb_rtc_time_setter.sv
// Bench for rtc_time_setter: directed table, corner sequences and a random
// run against an integer-arithmetic reference model.
module tb_rtc_time_setter;

  localparam int TO = 20;
`ifdef AUTO_REPEAT_EN
  localparam int RDLY = 10;
  localparam int RPER = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_btn, inc_btn;
  logic [23:0] cur;
  logic [3:0]  set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl;
  logic        load, setting;
  logic [1:0]  field_sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rtc_time_setter #(
    .TIMEOUT(TO)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DLY(RDLY),
    .REPEAT_PER(RPER)
`endif
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_hrm(cur[23:20]), .cur_hrl(cur[19:16]), .cur_minm(cur[15:12]),
    .cur_minl(cur[11:8]), .cur_secm(cur[7:4]), .cur_secl(cur[3:0]),
    .set_hrm(set_hrm), .set_hrl(set_hrl), .set_minm(set_minm),
    .set_minl(set_minl), .set_secm(set_secm), .set_secl(set_secl),
    .load(load), .setting(setting), .field_sel(field_sel)
  );

  // Reference model: fields held as digit pairs, arithmetic done in decimal
  int m_st, m_load, m_mq, m_iq, m_age, m_cyc, m_last;
  int m_d[6];

  function automatic void model_reset();
    m_st = 0; m_load = 0; m_mq = 1; m_iq = 1; m_age = -1; m_last = m_cyc;
    for (int k = 0; k < 6; k++) m_d[k] = 0;
  endfunction

  function automatic void bump(input int f);
    int hi, mx, v;
    hi = 2 * (f - 1);
    mx = (f == 1) ? 23 : 59;
    v  = m_d[hi] * 10 + m_d[hi+1];
    if (m_d[hi+1] > 9 || v > mx) v = 0;
    else v = (v + 1) % (mx + 1);
    m_d[hi]   = v / 10;
    m_d[hi+1] = v % 10;
  endfunction

  function automatic void model_step(input logic m, input logic i, input logic [23:0] c);
    bit mp, ipr, ip, fire;
    mp  = m && (m_mq == 0);
    ipr = i && (m_iq == 0);
    ip  = ipr && !mp;
    fire = 0;
    m_load = 0;
    m_cyc++;
`ifdef AUTO_REPEAT_EN
    if (m_st == 0 || !i || mp) m_age = -1;
    else if (ip) m_age = 0;
    else if (m_age >= 0) begin
      m_age++;
      if (m_age == RDLY || (m_age > RDLY && (m_age - RDLY) % RPER == 0)) fire = 1;
    end
`endif
    if (m_st == 0) begin
      if (mp) begin
        for (int k = 0; k < 6; k++) m_d[k] = int'(c[23-4*k -: 4]);
        m_st = 1;
        m_last = m_cyc;
      end
    end else if (mp) begin
      if (m_st == 3) m_load = 1;
      m_st = (m_st + 1) % 4;
      m_last = m_cyc;
    end else begin
      if (ip || fire) bump(m_st);
      if (ipr || fire) m_last = m_cyc;
      else if (m_cyc - m_last >= TO) m_st = 0;
    end
    m_mq = int'(m);
    m_iq = int'(i);
  endfunction

  function automatic logic [31:0] model_vec();
    return {4'h0, 4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3]), 4'(m_d[4]),
            4'(m_d[5]), 1'(m_load), 1'(m_st != 0), 2'(m_st)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {4'h0, set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl,
            load, setting, field_sel};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic m, input logic i, input logic [23:0] c);
    @(negedge clk);
    mode_btn = m; inc_btn = i; cur = c;
    model_step(m, i, c);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_chk(input logic m, input logic i, input logic [23:0] c);
    apply(m, i, c);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic press_mode(input logic [23:0] c);
    apply_chk(1'b1, 1'b0, c);
    apply_chk(1'b0, 1'b0, c);
  endtask

  task automatic press_inc(input logic [23:0] c);
    apply_chk(1'b0, 1'b1, c);
    apply_chk(1'b0, 1'b0, c);
  endtask

  // Asynchronous reset mid-cycle with both buttons held high
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0; mode_btn = 1'b1; inc_btn = 1'b1;
    model_reset();
    #1;
    check("async_reset", dut_vec(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        mode;
    logic        inc;
    logic [23:0] cur;
    logic [23:0] exp_set;
    logic        exp_load;
    logic        exp_setting;
    logic [1:0]  exp_fs;
  } vec_t;

  function automatic vec_t mk(input logic m, input logic i, input logic [23:0] es,
                              input logic ld, input logic st, input logic [1:0] fs);
    vec_t v;
    v.mode = m; v.inc = i; v.cur = 24'h123456;
    v.exp_set = es; v.exp_load = ld; v.exp_setting = st; v.exp_fs = fs;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] c;
    logic [23:0] hr_cur[4];
    logic [7:0]  hr_exp[4];
    logic        m, i;

    vecs[0]  = mk(1, 1, 24'h000000, 0, 0, 2'd0);
    vecs[1]  = mk(0, 0, 24'h000000, 0, 0, 2'd0);
    vecs[2]  = mk(1, 0, 24'h123456, 0, 1, 2'd1);
    vecs[3]  = mk(0, 0, 24'h123456, 0, 1, 2'd1);
    vecs[4]  = mk(0, 1, 24'h133456, 0, 1, 2'd1);
    vecs[5]  = mk(0, 0, 24'h133456, 0, 1, 2'd1);
    vecs[6]  = mk(0, 1, 24'h143456, 0, 1, 2'd1);
    vecs[7]  = mk(0, 0, 24'h143456, 0, 1, 2'd1);
    vecs[8]  = mk(1, 0, 24'h143456, 0, 1, 2'd2);
    vecs[9]  = mk(0, 0, 24'h143456, 0, 1, 2'd2);
    vecs[10] = mk(0, 1, 24'h143556, 0, 1, 2'd2);
    vecs[11] = mk(0, 0, 24'h143556, 0, 1, 2'd2);
    vecs[12] = mk(1, 1, 24'h143556, 0, 1, 2'd3);
    vecs[13] = mk(0, 0, 24'h143556, 0, 1, 2'd3);
    vecs[14] = mk(0, 1, 24'h143557, 0, 1, 2'd3);
    vecs[15] = mk(0, 0, 24'h143557, 0, 1, 2'd3);
    vecs[16] = mk(1, 0, 24'h143557, 1, 0, 2'd0);
    vecs[17] = mk(0, 0, 24'h143557, 0, 0, 2'd0);
    vecs[18] = mk(0, 1, 24'h143557, 0, 0, 2'd0);
    vecs[19] = mk(1, 1, 24'h123456, 0, 1, 2'd1);

    m_cyc = 0;
    rst = 1'b0; mode_btn = 1'b1; inc_btn = 1'b1; cur = '0;
    model_reset();
    do_reset();

    for (int k = 0; k < 20; k++) begin
      apply(vecs[k].mode, vecs[k].inc, vecs[k].cur);
      check($sformatf("vec%0d", k), dut_vec(),
            {4'h0, vecs[k].exp_set, vecs[k].exp_load, vecs[k].exp_setting, vecs[k].exp_fs});
      check("vec_model", dut_vec(), model_vec());
    end

    // 12:34:56, 13 hour steps then commit
    do_reset();
    c = 24'h123456;
    apply_chk(1'b0, 1'b0, c);
    press_mode(c);
    repeat (13) press_inc(c);
    check("hr_after_13", {24'h0, set_hrm, set_hrl}, 32'h01);
    press_mode(c);
    press_mode(c);
    apply_chk(1'b1, 1'b0, c);
    check("commit", dut_vec(), {4'h0, 24'h013456, 1'b1, 1'b0, 2'd0});
    apply_chk(1'b0, 1'b0, c);
    check("load_one_cycle", {31'h0, load}, 32'h0);

    // Minutes 58 -> 59 -> 00, other fields untouched
    do_reset();
    c = 24'h105807;
    apply_chk(1'b0, 1'b0, c);
    press_mode(c);
    press_mode(c);
    press_inc(c);
    check("min_59", {8'h0, set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl}, 32'h105907);
    press_inc(c);
    check("min_wrap", {8'h0, set_hrm, set_hrl, set_minm, set_minl, set_secm, set_secl}, 32'h100007);

    // Hour wrap, carry and illegal-capture clamp
    hr_cur[0] = 24'h290000; hr_exp[0] = 8'h00;
    hr_cur[1] = 24'h230000; hr_exp[1] = 8'h00;
    hr_cur[2] = 24'h091500; hr_exp[2] = 8'h10;
    hr_cur[3] = 24'h195959; hr_exp[3] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      apply_chk(1'b0, 1'b0, hr_cur[k]);
      press_mode(hr_cur[k]);
      press_inc(hr_cur[k]);
      check($sformatf("hr_case%0d", k), {24'h0, set_hrm, set_hrl}, {24'h0, hr_exp[k]});
    end

    // Inactivity abort after TO cycles in SET_HR
    do_reset();
    c = 24'h081530;
    apply_chk(1'b0, 1'b0, c);
    apply_chk(1'b1, 1'b0, c);
    for (int k = 1; k < TO; k++) begin
      apply_chk(1'b0, 1'b0, c);
      check("to_wait", {30'h0, load, setting}, 32'h1);
    end
    apply_chk(1'b0, 1'b0, c);
    check("to_abort", dut_vec(), {4'h0, 24'h081530, 1'b0, 1'b0, 2'd0});

    // Reset while editing discards the edits
    do_reset();
    c = 24'h111111;
    apply_chk(1'b0, 1'b0, c);
    press_mode(c);
    press_inc(c);
    do_reset();
    apply_chk(1'b0, 1'b0, c);

`ifdef AUTO_REPEAT_EN
    // Hold inc in SET_SEC: press plus repeats at 10, 14, 18, 22
    do_reset();
    c = 24'h000000;
    apply_chk(1'b0, 1'b0, c);
    press_mode(c);
    press_mode(c);
    press_mode(c);
    for (int k = 0; k <= 22; k++) apply_chk(1'b0, 1'b1, c);
    apply_chk(1'b0, 1'b0, c);
    check("auto_repeat", {24'h0, set_secm, set_secl}, 32'h05);
`endif

    // Random buttons and live time against the model
    do_reset();
    m = 1'b0; i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 500) >= 470) begin
        m = 1'b0;
      end else begin
        if ($urandom_range(0, 5) == 0) m = ~m;
        if ($urandom_range(0, 2) == 0) i = ~i;
      end
      for (int k = 0; k < 6; k++)
        c[23-4*k -: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(0, 9));
      apply_chk(m, i, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
